// File: rtl/logic_pair_pkg.sv
// Shared types and constants for the logic_pair_pipe block.
// Parity generation is controlled by LOGIC_PAIR_PIPE_PARITY_EN.
package logic_pair_pkg;

  localparam int unsigned HITS_W = 16;
  localparam logic [HITS_W-1:0] HITS_MAX = '1;

  // Payload lanes are sized for the widest supported operand; narrower
  // instances zero-extend and the unused upper bits are constant zero.
  localparam int unsigned MAX_W = 32;

  typedef struct packed {
    logic [MAX_W-1:0] x;
    logic [MAX_W-1:0] y;
    logic             x_par;
    logic             y_par;
  } pair_payload_t;

  // Per-bit function: x = a ^ b, y = (~a & c) | (b & c), plus optional parity.
  function automatic pair_payload_t pair_func(input logic [MAX_W-1:0] a,
                                              input logic [MAX_W-1:0] b,
                                              input logic [MAX_W-1:0] c);
    pair_payload_t p;
    p.x = a ^ b;
    p.y = (~a & c) | (b & c);
`ifdef LOGIC_PAIR_PIPE_PARITY_EN
    p.x_par = ^p.x;
    p.y_par = ^p.y;
`else
    p.x_par = 1'b0;
    p.y_par = 1'b0;
`endif
    return p;
  endfunction

endpackage

// File: rtl/pair_stage.sv
// One valid/ready register stage carrying a pair_payload_t.
// Loads when empty or when its current contents leave in the same cycle.
module pair_stage
  import logic_pair_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  output logic          up_ready,
  input  pair_payload_t up_data,
  output logic          dn_valid,
  input  logic          dn_ready,
  output pair_payload_t dn_data
);

  logic          valid_q;
  pair_payload_t data_q;

  // Ready is held low during reset so nothing is accepted into a flushing pipe.
  assign up_ready = !rst && (!valid_q || dn_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (up_ready) begin
      valid_q <= up_valid;
      if (up_valid) begin
        data_q <= up_data;
      end
    end
  end

  assign dn_valid = valid_q;
  assign dn_data  = data_q;

endmodule

// File: rtl/logic_pair_pipe.sv
// XOR / select-style logic pair with a STAGES-deep valid/ready pipeline and
// a saturating hit counter. Parity outputs depend on LOGIC_PAIR_PIPE_PARITY_EN.
module logic_pair_pipe
  import logic_pair_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [WIDTH-1:0]  c,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  x,
  output logic [WIDTH-1:0]  y,
  output logic              x_par,
  output logic              y_par,
  output logic [HITS_W-1:0] x_hits
);

  logic [STAGES:0] stg_valid;
  logic [STAGES:0] stg_ready;
  pair_payload_t   stg_data [STAGES+1];
  pair_payload_t   last;
  logic [HITS_W-1:0] hits_q;
  logic            hit_c;

  // Function logic sits ahead of the first register stage.
  assign stg_valid[0]      = in_valid;
  assign stg_data[0]       = pair_func(MAX_W'(a), MAX_W'(b), MAX_W'(c));
  assign in_ready          = stg_ready[0];
  assign stg_ready[STAGES] = out_ready;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    pair_stage u_stage (
      .clk      (clk),
      .rst      (rst),
      .up_valid (stg_valid[i]),
      .up_ready (stg_ready[i]),
      .up_data  (stg_data[i]),
      .dn_valid (stg_valid[i+1]),
      .dn_ready (stg_ready[i+1]),
      .dn_data  (stg_data[i+1])
    );
  end

  assign last      = stg_data[STAGES];
  assign out_valid = stg_valid[STAGES];
  assign x         = last.x[WIDTH-1:0];
  assign y         = last.y[WIDTH-1:0];

`ifdef LOGIC_PAIR_PIPE_PARITY_EN
  assign x_par = last.x_par;
  assign y_par = last.y_par;
`else
  assign x_par = 1'b0;
  assign y_par = 1'b0;

  logic unused_par;
  assign unused_par = last.x_par ^ last.y_par;
`endif

  // Upper payload bits are zero for narrow instances and never reach a port.
  logic unused_hi;
  if (WIDTH < MAX_W) begin : g_hi
    assign unused_hi = ^{last.x[MAX_W-1:WIDTH], last.y[MAX_W-1:WIDTH]};
  end else begin : g_full
    assign unused_hi = 1'b0;
  end

  // Saturating count of delivered results with nonzero x.
  assign hit_c = out_valid && out_ready && (x != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      hits_q <= '0;
    end else if (hit_c && (hits_q != HITS_MAX)) begin
      hits_q <= hits_q + HITS_W'(1);
    end
  end

  assign x_hits = hits_q;

endmodule

// File: tb/tb_logic_pair_pipe.sv
// Randomized, self-checking bench for logic_pair_pipe (WIDTH=4, STAGES=2).
// Honours LOGIC_PAIR_PIPE_PARITY_EN for the expected parity outputs.
module tb_logic_pair_pipe;

  localparam int unsigned W = 4;
  localparam int unsigned S = 2;

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         xp;
    logic         yp;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] c;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         x_par;
  logic         y_par;
  logic [15:0]  x_hits;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   mhits   = 0;
  exp_t exp_q[$];

  logic_pair_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .out_valid(out_valid), .out_ready(out_ready),
    .x(x), .y(y), .x_par(x_par), .y_par(y_par), .x_hits(x_hits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: truth-table per bit, parity from a population count.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic [W-1:0] mc);
    exp_t e;
    int   ones_x;
    int   ones_y;
    ones_x = 0;
    ones_y = 0;
    for (int i = 0; i < int'(W); i++) begin
      e.x[i] = (ma[i] != mb[i]);
      e.y[i] = mc[i] && (mb[i] || !ma[i]);
      ones_x += int'(e.x[i]);
      ones_y += int'(e.y[i]);
    end
`ifdef LOGIC_PAIR_PIPE_PARITY_EN
    e.xp = (ones_x % 2) == 1;
    e.yp = (ones_y % 2) == 1;
`else
    e.xp = 1'b0;
    e.yp = 1'b0;
`endif
    return e;
  endfunction

  task automatic randomize_ops();
    a = W'($urandom);
    b = W'($urandom);
    c = W'($urandom);
  endtask

  // Advance one cycle: observe handshakes mid-cycle, maintain the model queue.
  task automatic tick(output bit acc, output bit del, output exp_t got,
                      output exp_t want, output bit have);
    @(negedge clk);
    acc    = in_valid && in_ready;
    del    = out_valid && out_ready;
    got.x  = x;
    got.y  = y;
    got.xp = x_par;
    got.yp = y_par;
    have   = 1'b0;
    want   = '0;
    if (del && exp_q.size() > 0) begin
      want = exp_q.pop_front();
      have = 1'b1;
      if (want.x != '0 && mhits < 65535) mhits++;
    end
    if (acc) exp_q.push_back(model(a, b, c));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    randomize_ops();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_tests++;
    if ({x, y} !== '0) begin n_fail++; $display("FAIL reset_xy got x=%h y=%h want 0", x, y); end
    n_tests++;
    if ({x_par, y_par} !== 2'b00) begin n_fail++; $display("FAIL reset_par got=%b%b want=00", x_par, y_par); end
    n_tests++;
    if (x_hits !== 16'h0000) begin n_fail++; $display("FAIL reset_hits got=%h want=0000", x_hits); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    mhits = 0;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    bit acc, del, have, seen;
    exp_t got, want, lit;
    int lat;
    lit.x = 4'b0110;
    lit.y = 4'b1011;
`ifdef LOGIC_PAIR_PIPE_PARITY_EN
    lit.xp = 1'b0;
    lit.yp = 1'b1;
`else
    lit.xp = 1'b0;
    lit.yp = 1'b0;
`endif
    a = 4'b1100; b = 4'b1010; c = 4'b1111;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick(acc, del, got, want, have);
    in_valid = 1'b0;
    n_tests++;
    if (!acc) begin n_fail++; $display("FAIL directed_accept got=%b want=1", acc); end
    seen = 1'b0;
    lat = -1;
    for (int k = 1; k <= 10 && !seen; k++) begin
      tick(acc, del, got, want, have);
      if (del) begin
        seen = 1'b1;
        lat = k;
        n_tests++;
        if (got !== lit) begin
          n_fail++;
          $display("FAIL directed_data got x=%b y=%b p=%b%b want x=%b y=%b p=%b%b",
                   got.x, got.y, got.xp, got.yp, lit.x, lit.y, lit.xp, lit.yp);
        end
      end
    end
    n_tests++;
    if (lat != int'(S)) begin n_fail++; $display("FAIL directed_latency got=%0d want=%0d", lat, S); end
  endtask

  task automatic test_backpressure();
    bit acc, del, have;
    exp_t got, want, held;
    int n_acc, n_del, last_k, gaps;
    bit third_acc;
    out_ready = 1'b0;
    in_valid = 1'b1;
    randomize_ops();
    n_acc = 0;
    third_acc = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(acc, del, got, want, have);
      if (acc) begin n_acc++; randomize_ops(); end
      if (k == 2) third_acc = acc;
    end
    n_tests++;
    if (n_acc != int'(S) || third_acc) begin
      n_fail++; $display("FAIL fill_accepts got=%0d third=%b want=%0d third=0", n_acc, third_acc, S);
    end
    tick(acc, del, held, want, have);
    tick(acc, del, got, want, have);
    n_tests++;
    if (out_valid !== 1'b1 || got !== held) begin
      n_fail++; $display("FAIL stall_hold got x=%h y=%h v=%b want x=%h y=%h v=1", got.x, got.y, out_valid, held.x, held.y);
    end
    out_ready = 1'b1;
    n_del = 0; last_k = -1; gaps = 0;
    for (int k = 0; k < 20 && n_del < 3; k++) begin
      tick(acc, del, got, want, have);
      if (acc) in_valid = 1'b0;
      if (del) begin
        n_tests++;
        if (!have || got !== want) begin
          n_fail++; $display("FAIL drain_data got x=%h y=%h p=%b%b want x=%h y=%h p=%b%b",
                             got.x, got.y, got.xp, got.yp, want.x, want.y, want.xp, want.yp);
        end
        if (last_k >= 0 && k != last_k + 1) gaps++;
        last_k = k;
        n_del++;
      end
    end
    n_tests++;
    if (n_del != 3 || gaps != 0) begin n_fail++; $display("FAIL drain_count got=%0d gaps=%0d want=3 gaps=0", n_del, gaps); end
  endtask

  task automatic test_back_to_back();
    bit acc, del, have;
    exp_t got, want;
    int n_acc, n_del, first_acc, first_del, last_del, gaps, refused;
    out_ready = 1'b1;
    in_valid = 1'b1;
    randomize_ops();
    n_acc = 0; n_del = 0; first_acc = -1; first_del = -1; last_del = -1; gaps = 0; refused = 0;
    for (int k = 0; k < 40 && n_del < 10; k++) begin
      tick(acc, del, got, want, have);
      if (acc) begin
        if (first_acc < 0) first_acc = k;
        n_acc++;
        if (n_acc == 10) in_valid = 1'b0;
        else randomize_ops();
      end else if (in_valid) begin
        refused++;
      end
      if (del) begin
        n_tests++;
        if (!have || got !== want) begin
          n_fail++; $display("FAIL b2b_data got x=%h y=%h want x=%h y=%h", got.x, got.y, want.x, want.y);
        end
        if (first_del < 0) first_del = k;
        else if (k != last_del + 1) gaps++;
        last_del = k;
        n_del++;
      end
    end
    n_tests++;
    if (n_del != 10 || gaps != 0 || refused != 0) begin
      n_fail++; $display("FAIL b2b_stream got del=%0d gaps=%0d refused=%0d want 10/0/0", n_del, gaps, refused);
    end
    n_tests++;
    if (first_del - first_acc != int'(S)) begin
      n_fail++; $display("FAIL b2b_latency got=%0d want=%0d", first_del - first_acc, S);
    end
  endtask

  task automatic test_random();
    bit acc, del, have;
    exp_t got, want;
    in_valid = 1'b1;
    randomize_ops();
    for (int k = 0; k < 300; k++) begin
      out_ready = ($urandom_range(0, 2) != 0);
      tick(acc, del, got, want, have);
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        randomize_ops();
      end
      if (del) begin
        n_tests++;
        if (!have || got !== want) begin
          n_fail++; $display("FAIL rand_data got x=%h y=%h p=%b%b want x=%h y=%h p=%b%b",
                             got.x, got.y, got.xp, got.yp, want.x, want.y, want.xp, want.yp);
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick(acc, del, got, want, have);
      if (del) begin
        n_tests++;
        if (!have || got !== want) begin
          n_fail++; $display("FAIL rand_drain got x=%h y=%h want x=%h y=%h", got.x, got.y, want.x, want.y);
        end
      end
    end
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_lost got=%0d pending want=0", exp_q.size()); end
    n_tests++;
    if (x_hits !== 16'(mhits)) begin n_fail++; $display("FAIL rand_hits got=%0d want=%0d", x_hits, mhits); end
  endtask

  task automatic test_reset_flush();
    bit acc, del, have;
    exp_t got, want;
    int ghosts;
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      randomize_ops();
      a[0] = ~b[0];
      tick(acc, del, got, want, have);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick(acc, del, got, want, have);
    rst = 1'b0;
    exp_q.delete();
    mhits = 0;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got=%b want=0", out_valid); end
    n_tests++;
    if (x_hits !== 16'h0000) begin n_fail++; $display("FAIL flush_hits got=%h want=0000", x_hits); end
    out_ready = 1'b1;
    ghosts = 0;
    for (int k = 0; k < 8; k++) begin
      tick(acc, del, got, want, have);
      if (del) ghosts++;
    end
    n_tests++;
    if (ghosts != 0) begin n_fail++; $display("FAIL flush_ghosts got=%0d want=0", ghosts); end
  endtask

  task automatic test_saturation();
    bit acc, del, have;
    exp_t got, want;
    int n_acc, n_del;
    out_ready = 1'b1;
    in_valid = 1'b0;
    force dut.hits_q = 16'hFFFE;
    #1;
    release dut.hits_q;
    mhits = 32'h0000FFFE;
    n_tests++;
    if (x_hits !== 16'hFFFE) begin n_fail++; $display("FAIL sat_preload got=%h want=fffe", x_hits); end
    n_acc = 0; n_del = 0;
    in_valid = 1'b1;
    a = W'($urandom); b = a ^ W'($urandom_range(1, 15)); c = W'($urandom);
    for (int k = 0; k < 20 && n_del < 3; k++) begin
      tick(acc, del, got, want, have);
      if (acc) begin
        n_acc++;
        if (n_acc == 3) in_valid = 1'b0;
        a = W'($urandom); b = a ^ W'($urandom_range(1, 15)); c = W'($urandom);
      end
      if (del) begin
        n_del++;
        n_tests++;
        if (x_hits !== 16'(mhits)) begin n_fail++; $display("FAIL sat_step got=%h want=%h", x_hits, 16'(mhits)); end
      end
    end
    n_tests++;
    if (x_hits !== 16'hFFFF || n_del != 3) begin
      n_fail++; $display("FAIL sat_final got=%h del=%0d want=ffff del=3", x_hits, n_del);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; c = '0;
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_flush();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_pair_pipe.md
LOGIC_PAIR_PIPE -- requirements
Module: logic_pair_pipe

Interface
REQ-001 Parameter WIDTH, default 4: bit width of each operand lane (1..32).
REQ-002 Parameter STAGES, default 2: pipeline register stages from input to output (1..4).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_valid  input  1  upstream presents operands.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a, b, c  input  WIDTH each  operand lanes.
REQ-008 out_valid  output  1  result available.
REQ-009 out_ready  input  1  downstream accepts result.
REQ-010 x, y  output  WIDTH each  results.
REQ-011 x_par, y_par  output  1 each  even parity of x, y.
REQ-012 x_hits  output  16  count of delivered results with x nonzero.

Function
REQ-013 Per bit i: x[i] = a[i] XOR b[i]; y[i] = (NOT a[i] AND c[i]) OR (b[i] AND c[i]).
REQ-014 Input transfer occurs when in_valid and in_ready are both 1; output transfer occurs when out_valid and out_ready are both 1.
REQ-015 Latency: a result accepted in cycle n appears with out_valid=1 in cycle n+STAGES when no backpressure applies.
REQ-016 Throughput: one transfer per cycle sustained while out_ready=1.
REQ-017 Each stage holds a valid bit; a stage loads when empty or when its contents move on in the same cycle.
REQ-018 in_ready = NOT stage1 valid OR stage1 advances this cycle; in_ready SHALL not depend combinationally on in_valid.
REQ-019 With out_ready=0, the pipeline fills; after STAGES accepted items in_ready=0, and no item is lost or duplicated.
REQ-020 While out_valid=1 and out_ready=0, x, y, x_par, y_par SHALL hold stable.
REQ-021 Results leave in acceptance order.
REQ-022 x_hits increments by 1 on each output transfer with x != 0, saturates at 16'hFFFF, and does not wrap.
REQ-023 Simultaneous input and output transfers in a full pipeline: both occur and occupancy is unchanged.

Reset
REQ-024 While rst=1 at a clock edge: all stage valid bits clear, out_valid=0, x=0, y=0, x_par=0, y_par=0, and x_hits=0.
REQ-025 in_ready=0 during any cycle with rst=1; in_ready becomes 1 in the first cycle after rst falls.
REQ-026 Reset mid-operation discards all in-flight items; none appear after reset.

Configuration
REQ-027 Macro LOGIC_PAIR_PIPE_PARITY_EN: when defined, x_par = XOR-reduce of x and y_par = XOR-reduce of y, registered with the data in the same stage.
REQ-028 When LOGIC_PAIR_PIPE_PARITY_EN is undefined, x_par and y_par are tied 0, no parity logic is generated, and the ports remain present.

Structure
REQ-029 Shared package logic_pair_pkg holds: the HITS_W=16 constant, the HITS_MAX constant, and a typedef for the stage payload struct {x, y, x_par, y_par}.
REQ-030 One sub-module, pair_stage, implements one valid/ready register stage; the top instantiates STAGES copies in a generate chain, with the function logic ahead of stage 1.

Verification (WIDTH=4, STAGES=2)
REQ-031 a=4'b1100, b=4'b1010, c=4'b1111, one transfer, out_ready=1 -> two cycles later out_valid=1, x=4'b0110, y=4'b1011, x_par=0, y_par=1 (PARITY_EN defined).
REQ-032 Hold out_ready=0 and offer 3 items -> first 2 accepted, in_ready=0 on the 3rd; raise out_ready -> 3 results delivered in order, no gaps after the first.
REQ-033 Stream 10 items back-to-back with out_ready=1 -> 10 results in consecutive cycles, starting 2 cycles after the first acceptance.
REQ-034 Assert rst for 1 cycle with 2 items in flight -> out_valid=0 next cycle, x_hits=0, and the flushed items never appear.
REQ-035 Preload x_hits near saturation (force 16'hFFFE), deliver 3 results with x != 0 -> x_hits=16'hFFFF and stays there.
REQ-036 Build without PARITY_EN and repeat REQ-031 -> x and y identical, x_par=y_par=0.
